// File: rtl/fifo_read_arbiter.sv
// Read side of the per-class transaction FIFOs: round-robin pops from two sources
// and pushes each word into one downstream FIFO, two cycles after its pop.
module fifo_read_arbiter #(
    parameter int DATA_W  = 10,
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic              empty0,
    input  logic              empty1,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic              almost_full_out,
    output logic              pop0,
    output logic              pop1,
    output logic              push_out,
    output logic [DATA_W-1:0] data_out,
    output logic [STATE_W-1:0] state,
    output logic              idle
);

    // Handshake: pop0/pop1 are single-cycle strobes taken by the source FIFO on the
    // same edge, with read data valid one cycle later; push_out is a single-cycle
    // strobe with data_out, and the only back-pressure is almost_full_out.
    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_e;

    state_e            state_q, state_d;
    logic              idle_q;
    logic              last_grant_q;
    logic              v1_q;
    logic              src1_q;
    logic              push_q;
    logic [DATA_W-1:0] data_q;

    logic can_pop;
    logic pop_any;
    logic grant1;
    logic in_flight;

    always_comb begin
        can_pop = (state_q == ST_ACTIVE) && !almost_full_out && !init;
        // Round-robin only matters when both sources have data.
        if (!empty0 && !empty1) begin
            grant1 = !last_grant_q;
        end else begin
            grant1 = empty0;
        end
        pop_any   = can_pop && !(empty0 && empty1);
        in_flight = v1_q || push_q;
    end

    assign pop0     = pop_any && !grant1;
    assign pop1     = pop_any && grant1;
    assign push_out = push_q;
    assign data_out = data_q;
    assign state    = STATE_W'(state_q);
    assign idle     = idle_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (!init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (!empty0 || !empty1) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // init stops new pops but words already popped still get pushed.
                if (init) begin
                    if (!in_flight) state_d = ST_INIT;
                end else if (empty0 && empty1 && !in_flight) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q      <= ST_RESET;
            idle_q       <= 1'b0;
            last_grant_q <= 1'b1;
            v1_q         <= 1'b0;
            src1_q       <= 1'b0;
            push_q       <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= (state_d == ST_IDLE);
            if (pop_any) begin
                last_grant_q <= grant1;
            end
            v1_q   <= pop_any;
            src1_q <= grant1;
            push_q <= v1_q;
            if (v1_q) begin
                data_q <= src1_q ? data_in1 : data_in0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: two source FIFO models, a scoreboard of
// hand-written expected pop sources and pushed words, and a one-line summary.
module tb_fifo_read_arbiter;

    localparam int DATA_W  = 10;
    localparam int STATE_W = 4;

    logic              clk = 1'b0;
    logic              reset_L;
    logic              init;
    logic              empty0, empty1;
    logic [DATA_W-1:0] data_in0, data_in1;
    logic              almost_full_out;
    logic              pop0, pop1, push_out;
    logic [DATA_W-1:0] data_out;
    logic [STATE_W-1:0] state;
    logic              idle;

    fifo_read_arbiter #(.DATA_W(DATA_W), .STATE_W(STATE_W)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .empty0(empty0), .empty1(empty1),
        .data_in0(data_in0), .data_in1(data_in1),
        .almost_full_out(almost_full_out),
        .pop0(pop0), .pop1(pop1), .push_out(push_out),
        .data_out(data_out), .state(state), .idle(idle)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- source FIFO models ----------------
    logic [DATA_W-1:0] mem0[64];
    logic [DATA_W-1:0] mem1[64];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    assign empty0 = (rd0 == wr0);
    assign empty1 = (rd1 == wr1);

    initial begin
        data_in0 = '0;
        data_in1 = '0;
    end

    always @(posedge clk) begin
        if (pop0 && !empty0) begin
            data_in0 <= mem0[rd0];
            rd0      <= rd0 + 1;
        end
        if (pop1 && !empty1) begin
            data_in1 <= mem1[rd1];
            rd1      <= rd1 + 1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_src_q[$];
    int                pop_cyc_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int pop_cnt = 0;
    int push_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (pop0 === 1'b1 || pop1 === 1'b1) begin
            pop_cnt++;
            check_eq("pop_onehot", {31'd0, pop0 & pop1}, 32'd0);
            if (pop0) check_eq("pop0_nonempty", {31'd0, empty0}, 32'd0);
            if (pop1) check_eq("pop1_nonempty", {31'd0, empty1}, 32'd0);
            if (exp_src_q.size() == 0) begin
                check_eq("pop_unexpected", 32'd1, 32'd0);
            end else begin
                check_eq("pop_src", {31'd0, pop1}, {31'd0, exp_src_q.pop_front()});
            end
            pop_cyc_q.push_back(cyc);
        end
        if (push_out === 1'b1) begin
            push_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("push_unexpected", 32'(data_out), 32'h0);
            end else begin
                check_eq("push_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
            if (pop_cyc_q.size() != 0) begin
                check_eq("push_latency", 32'(cyc - pop_cyc_q.pop_front()), 32'd2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load0(input logic [DATA_W-1:0] v);
        mem0[wr0] = v;
        wr0 = wr0 + 1;
    endtask

    task automatic load1(input logic [DATA_W-1:0] v);
        mem1[wr1] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic expect_word(input logic src, input logic [DATA_W-1:0] v);
        exp_src_q.push_back(src);
        exp_q.push_back(v);
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (idle === 1'b1 && exp_q.size() == 0 && exp_src_q.size() == 0) break;
        end
        check_eq({tag, "_idle"}, {31'd0, idle}, 32'd1);
        check_eq({tag, "_drained"}, 32'(exp_q.size() + exp_src_q.size()), 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int p0, q0, seen, blocked, late_push;
        reset_L = 1'b0;
        init = 1'b1;
        almost_full_out = 1'b0;

        // Reset and init
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", 32'(state), 32'h1);
        check_eq("rst_pop0", {31'd0, pop0}, 32'd0);
        check_eq("rst_pop1", {31'd0, pop1}, 32'd0);
        check_eq("rst_push", {31'd0, push_out}, 32'd0);
        check_eq("rst_idle", {31'd0, idle}, 32'd0);
        check_eq("rst_data", 32'(data_out), 32'h0);
        reset_L = 1'b1;
        @(negedge clk);
        check_eq("init_state", 32'(state), 32'h2);
        @(negedge clk);
        check_eq("init_hold", 32'(state), 32'h2);
        init = 1'b0;
        @(negedge clk);
        check_eq("idle_state", 32'(state), 32'h4);
        check_eq("idle_flag", {31'd0, idle}, 32'd1);

        // Round-robin, fresh from reset so source 0 wins first
        expect_word(1'b0, 10'h100);
        expect_word(1'b1, 10'h200);
        expect_word(1'b0, 10'h101);
        expect_word(1'b1, 10'h201);
        load0(10'h100); load0(10'h101);
        load1(10'h200); load1(10'h201);
        wait_idle("rr", 40);

        // Single source
        p0 = pop_cnt;
        expect_word(1'b0, 10'h011);
        expect_word(1'b0, 10'h022);
        expect_word(1'b0, 10'h033);
        load0(10'h011); load0(10'h022); load0(10'h033);
        wait_idle("single", 40);
        check_eq("single_pops", 32'(pop_cnt - p0), 32'd3);

        // Back-pressure after the second pop
        expect_word(1'b0, 10'h300);
        expect_word(1'b0, 10'h301);
        expect_word(1'b0, 10'h302);
        expect_word(1'b0, 10'h303);
        load0(10'h300); load0(10'h301); load0(10'h302); load0(10'h303);
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (pop0 === 1'b1) seen++;
        end
        check_eq("bp_two_pops", 32'(seen), 32'd2);
        @(posedge clk);
        #1 almost_full_out = 1'b1;
        q0 = push_cnt;
        blocked = 0;
        repeat (5) begin
            @(negedge clk);
            if (pop0 === 1'b1 || pop1 === 1'b1) blocked++;
        end
        check_eq("bp_no_pop", 32'(blocked), 32'd0);
        check_eq("bp_inflight_pushes", 32'(push_cnt - q0), 32'd2);
        almost_full_out = 1'b0;
        wait_idle("bp", 40);

        // Empty edge: one word in FIFO1 only
        p0 = pop_cnt;
        q0 = push_cnt;
        expect_word(1'b1, 10'h3ab);
        load1(10'h3ab);
        wait_idle("edge", 40);
        check_eq("edge_pops", 32'(pop_cnt - p0), 32'd1);
        check_eq("edge_pushes", 32'(push_cnt - q0), 32'd1);

        // Reset the cycle after a pop: in-flight words are dropped
        expect_word(1'b0, 10'h3c0);
        expect_word(1'b0, 10'h3c1);
        load0(10'h3c0); load0(10'h3c1);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (pop0 === 1'b1) seen = 1;
        end
        check_eq("mid_pop_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1 reset_L = 1'b0;
        init = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_src_q.delete();
        pop_cyc_q.delete();
        q0 = push_cnt;
        late_push = 0;
        @(negedge clk);
        check_eq("mid_rst_state", 32'(state), 32'h1);
        check_eq("mid_rst_push", {31'd0, push_out}, 32'd0);
        reset_L = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (push_out === 1'b1) late_push++;
        end
        check_eq("mid_no_push", 32'(late_push), 32'd0);
        check_eq("mid_push_cnt", 32'(push_cnt - q0), 32'd0);
        check_eq("mid_init_state", 32'(state), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
- Consumer (read) side of the transaction-layer FIFOs.
- Pops words from two source FIFOs (class 0 and class 1) using their empty flags.
- Arbitrates round-robin between the two sources.
- Pushes each retrieved word into one downstream FIFO and respects that FIFO's almost_full back-pressure.
- Sits between the per-class buffers and the next pipeline stage, exercising the push/pop/almost-flag interface from the reading end.

Parameters:
- DATA_W, 10, word width of source and destination data.
- STATE_W, 4, width of the one-hot state output.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_L  input  1  synchronous active-low reset.
- init  input  1  1 = hold block in INIT (no traffic).
- empty0  input  1  source FIFO 0 empty (reflects current occupancy, updates the cycle after a pop).
- empty1  input  1  source FIFO 1 empty.
- data_in0  input  DATA_W  source FIFO 0 read data; valid the cycle after pop0.
- data_in1  input  DATA_W  source FIFO 1 read data; valid the cycle after pop1.
- almost_full_out  input  1  destination FIFO almost_full.
- pop0  output  1  pop strobe to source FIFO 0.
- pop1  output  1  pop strobe to source FIFO 1.
- push_out  output  1  push strobe to destination FIFO.
- data_out  output  DATA_W  word pushed to destination.
- state  output  STATE_W  current FSM state, one-hot.
- idle  output  1  1 while in IDLE.

Behaviour:
- Reset:
  - reset_L sampled low at a clock edge: all outputs 0 after that edge, except state=4'b0001 (RESET).
  - In-flight pipeline is cleared; last_grant is reset to 1, so source 0 wins first.
  - Reset mid-transfer discards in-flight words; no push is issued after the reset edge.
- FSM states: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000. Transitions:
  - RESET: goes to INIT on the first edge with reset_L=1.
  - INIT: stays while init=1; goes to IDLE when init=0. No pops in INIT.
  - IDLE: goes to ACTIVE when init=0 and (!empty0 or !empty1); goes to INIT when init=1. idle=1 only here.
  - ACTIVE: goes to IDLE when empty0 & empty1 and no word is in flight.
  - ACTIVE: when init=1, stops issuing pops, drains in-flight words, then goes to INIT.
- Pop issue (combinational from registered state and flags, ACTIVE only): a pop may issue only when almost_full_out=0 and init=0.
  - Only one of pop0/pop1 is asserted per cycle; an empty source is never popped.
  - Both sources non-empty: grant the source not granted last (round-robin); last_grant updates on each pop.
  - Only one source non-empty: grant it, regardless of last_grant.
  - Pops may issue on back-to-back cycles. Throughput is 1 word/cycle.
- Data path, latency 2:
  - Pop in cycle N.
  - In cycle N+1 the selected data_inX is registered, together with the source id.
  - In cycle N+2, push_out=1 and data_out=that word, for exactly one cycle per pop.
  - Word order at the output equals pop order.
- Back-pressure:
  - almost_full_out=1 blocks new pops immediately.
  - Up to 2 words already in flight are still pushed. The destination threshold must leave at least 2 free slots.
- Data width: data passes through unmodified. data_out holds its last value when push_out=0.

Test Plan:
- Reset and init:
  - reset_L=0 for 2 cycles → state=0001, pop0=pop1=push_out=0.
  - Release with init=1 → state=0010.
  - init=0 → state=0100, idle=1.
- Single source:
  - FIFO0 holds 0x011, 0x022, 0x033; FIFO1 empty.
  - Expect pop0 on 3 consecutive cycles, pop1 never.
  - Expect push_out on cycles N+2..N+4 with data_out 0x011, 0x022, 0x033; then return to IDLE.
- Round-robin:
  - FIFO0 holds 0x100, 0x101; FIFO1 holds 0x200, 0x201.
  - Expect pop order 0,1,0,1 and output order 0x100, 0x200, 0x101, 0x201.
- Back-pressure:
  - Raise almost_full_out after the 2nd pop → no pop that cycle; exactly 2 pushes complete.
  - Drop almost_full_out → popping resumes with the correct next word.
- Empty edge:
  - FIFO1 holds 1 word, FIFO0 empty → exactly one pop1.
  - No second pop after empty1 rises. Single push; then IDLE.
- Mid-transfer reset:
  - Assert reset_L=0 the cycle after a pop → no push_out in following cycles; state=0001.
